// File: rtl/slink_attr_pkg.sv
// slink_attr_pkg
//   Constants shared by the attribute sequencer and the send/recv FIFO
//   wrapper: attribute field widths and the read-timeout fill value.
package slink_attr_pkg;

    localparam int ATTR_ADDR_W = 16;
    localparam int ATTR_DATA_W = 16;

    localparam int                     RSP_TIMEOUT_DEFAULT   = 1024;
    localparam logic [ATTR_DATA_W-1:0] TIMEOUT_RDATA_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/slink_attr_rsp_timer.sv
// slink_attr_rsp_timer
//   Read-response down-counter.
//   Ports:
//     link_clk, link_reset : clock, synchronous active-high reset
//     load                 : load the counter with MAX_COUNT
//     dec                  : decrement by one, saturating at zero
//     expired              : this decrement brings the counter to zero
module slink_attr_rsp_timer #(
    parameter int MAX_COUNT = 1024,
    parameter int W         = $clog2(MAX_COUNT + 1)
) (
    input  logic link_clk,
    input  logic link_reset,
    input  logic load,
    input  logic dec,
    output logic expired
);

    logic [W-1:0] count;

    always_ff @(posedge link_clk) begin
        if (link_reset) begin
            count <= '0;
        end else if (load) begin
            count <= W'(MAX_COUNT);
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    // The last waiting cycle is the one where count is 1; <= also covers a
    // counter that is already empty so the wait can never stall.
    assign expired = dec && (count <= W'(1));

endmodule

// File: rtl/slink_attr_sequencer.sv
// slink_attr_sequencer
//   Link-clock sequencer: pops attribute requests from the send FIFO, issues
//   them as attribute packets and, for reads, pushes the response (or the
//   timeout fill value) into the recv FIFO. One transaction at a time.
//   Ports:
//     link_clk, link_reset              : clock, synchronous active-high reset
//     enable, err_clr                   : start permission, sticky-error clear
//     send_fifo_*, send_attr_*          : show-ahead send FIFO head and pop
//     attr_pkt_*                        : packet valid/ready handshake to link
//     attr_rsp_valid, attr_rsp_data     : read response strobe from link
//     recv_fifo_full, recv_fifo_winc,
//     recv_attr_rdata                   : recv FIFO push interface
//     attr_busy, err_timeout,
//     err_unexp_rsp                     : status
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | no transaction; pops the send FIFO when enabled and non-empty
//   SEND     | attribute packet offered, waiting for attr_pkt_ready
//   WAIT_RSP | read issued, waiting for the response or the timer
//   PUSH     | read data held, waiting for room in the recv FIFO
module slink_attr_sequencer
    import slink_attr_pkg::*;
#(
    parameter int                     RSP_TIMEOUT   = RSP_TIMEOUT_DEFAULT,
    parameter logic [ATTR_DATA_W-1:0] TIMEOUT_RDATA = TIMEOUT_RDATA_DEFAULT
) (
    input  logic                   link_clk,
    input  logic                   link_reset,
    input  logic                   enable,
    input  logic                   err_clr,
    input  logic                   send_fifo_empty,
    input  logic [ATTR_ADDR_W-1:0] send_attr_addr,
    input  logic [ATTR_DATA_W-1:0] send_attr_wdata,
    input  logic                   send_attr_wr,
    output logic                   send_fifo_rinc,
    output logic                   attr_pkt_valid,
    input  logic                   attr_pkt_ready,
    output logic [ATTR_ADDR_W-1:0] attr_pkt_addr,
    output logic [ATTR_DATA_W-1:0] attr_pkt_data,
    output logic                   attr_pkt_wr,
    input  logic                   attr_rsp_valid,
    input  logic [ATTR_DATA_W-1:0] attr_rsp_data,
    input  logic                   recv_fifo_full,
    output logic                   recv_fifo_winc,
    output logic [ATTR_DATA_W-1:0] recv_attr_rdata,
    output logic                   attr_busy,
    output logic                   err_timeout,
    output logic                   err_unexp_rsp
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SEND     = 2'd1;
    localparam logic [1:0] ST_WAIT_RSP = 2'd2;
    localparam logic [1:0] ST_PUSH     = 2'd3;

    localparam int TMR_W = $clog2(RSP_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        SEND     = ST_SEND,
        WAIT_RSP = ST_WAIT_RSP,
        PUSH     = ST_PUSH
    } state_t;

    state_t                 state;
    logic [ATTR_DATA_W-1:0] hold_rdata;

    logic pop;
    logic rsp_direct;
    logic push;
    logic unexp_rsp;
    logic tmr_load;
    logic tmr_dec;
    logic tmr_expired;
    logic timeout_hit;

    slink_attr_rsp_timer #(
        .MAX_COUNT (RSP_TIMEOUT),
        .W         (TMR_W)
    ) u_rsp_timer (
        .link_clk   (link_clk),
        .link_reset (link_reset),
        .load       (tmr_load),
        .dec        (tmr_dec),
        .expired    (tmr_expired)
    );

    // Pop and push strobes are combinational so the pop lands in the IDLE
    // cycle and a direct response is pushed in the cycle it arrives. Both are
    // blocked while reset is asserted so an abandoned transaction leaves the
    // FIFOs untouched.
    always_comb begin
        pop         = !link_reset && (state == IDLE) && enable && !send_fifo_empty;
        rsp_direct  = (state == WAIT_RSP) && attr_rsp_valid && !recv_fifo_full;
        push        = !link_reset && (rsp_direct || ((state == PUSH) && !recv_fifo_full));
        unexp_rsp   = attr_rsp_valid && (state != WAIT_RSP);
        tmr_load    = (state == SEND) && attr_pkt_ready && !attr_pkt_wr;
        tmr_dec     = (state == WAIT_RSP);
        // A response on the expiry cycle wins over the timeout.
        timeout_hit = (state == WAIT_RSP) && !attr_rsp_valid && tmr_expired;
    end

    assign send_fifo_rinc  = pop;
    assign recv_fifo_winc  = push;
    assign recv_attr_rdata = ((state == WAIT_RSP) && attr_rsp_valid) ? attr_rsp_data : hold_rdata;

    always_ff @(posedge link_clk) begin
        if (link_reset) begin
            state          <= IDLE;
            attr_pkt_valid <= 1'b0;
            attr_pkt_addr  <= '0;
            attr_pkt_data  <= '0;
            attr_pkt_wr    <= 1'b0;
            attr_busy      <= 1'b0;
            hold_rdata     <= '0;
            err_timeout    <= 1'b0;
            err_unexp_rsp  <= 1'b0;
        end else begin
            // Set has priority over clear.
            if (unexp_rsp) begin
                err_unexp_rsp <= 1'b1;
            end else if (err_clr) begin
                err_unexp_rsp <= 1'b0;
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        state          <= SEND;
                        attr_pkt_valid <= 1'b1;
                        attr_busy      <= 1'b1;
                        attr_pkt_addr  <= send_attr_addr;
                        attr_pkt_data  <= send_attr_wr ? send_attr_wdata : '0;
                        attr_pkt_wr    <= send_attr_wr;
                    end
                end
                SEND: begin
                    if (attr_pkt_ready) begin
                        attr_pkt_valid <= 1'b0;
                        if (attr_pkt_wr) begin
                            state     <= IDLE;
                            attr_busy <= 1'b0;
                        end else begin
                            state <= WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (attr_rsp_valid) begin
                        hold_rdata <= attr_rsp_data;
                        if (!recv_fifo_full) begin
                            state     <= IDLE;
                            attr_busy <= 1'b0;
                        end else begin
                            state <= PUSH;
                        end
                    end else if (tmr_expired) begin
                        hold_rdata <= TIMEOUT_RDATA;
                        state      <= PUSH;
                    end
                end
                PUSH: begin
                    if (!recv_fifo_full) begin
                        state     <= IDLE;
                        attr_busy <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    attr_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slink_attr_sequencer.sv
module tb_slink_attr_sequencer;
    import slink_attr_pkg::*;

    localparam int TO = 8;

    logic        link_clk = 1'b0;
    logic        link_reset = 1'b1;
    logic        enable = 1'b0;
    logic        err_clr = 1'b0;
    logic        send_fifo_empty = 1'b1;
    logic [15:0] send_attr_addr = '0;
    logic [15:0] send_attr_wdata = '0;
    logic        send_attr_wr = 1'b0;
    logic        send_fifo_rinc;
    logic        attr_pkt_valid;
    logic        attr_pkt_ready = 1'b0;
    logic [15:0] attr_pkt_addr;
    logic [15:0] attr_pkt_data;
    logic        attr_pkt_wr;
    logic        attr_rsp_valid = 1'b0;
    logic [15:0] attr_rsp_data = '0;
    logic        recv_fifo_full = 1'b0;
    logic        recv_fifo_winc;
    logic [15:0] recv_attr_rdata;
    logic        attr_busy;
    logic        err_timeout;
    logic        err_unexp_rsp;

    always #5 link_clk = ~link_clk;

    slink_attr_sequencer #(.RSP_TIMEOUT(TO)) dut (
        .link_clk        (link_clk),
        .link_reset      (link_reset),
        .enable          (enable),
        .err_clr         (err_clr),
        .send_fifo_empty (send_fifo_empty),
        .send_attr_addr  (send_attr_addr),
        .send_attr_wdata (send_attr_wdata),
        .send_attr_wr    (send_attr_wr),
        .send_fifo_rinc  (send_fifo_rinc),
        .attr_pkt_valid  (attr_pkt_valid),
        .attr_pkt_ready  (attr_pkt_ready),
        .attr_pkt_addr   (attr_pkt_addr),
        .attr_pkt_data   (attr_pkt_data),
        .attr_pkt_wr     (attr_pkt_wr),
        .attr_rsp_valid  (attr_rsp_valid),
        .attr_rsp_data   (attr_rsp_data),
        .recv_fifo_full  (recv_fifo_full),
        .recv_fifo_winc  (recv_fifo_winc),
        .recv_attr_rdata (recv_attr_rdata),
        .attr_busy       (attr_busy),
        .err_timeout     (err_timeout),
        .err_unexp_rsp   (err_unexp_rsp)
    );

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        wr;
    } req_t;

    req_t fifo[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Transaction-level reference: which phase the single outstanding request
    // is in, the request itself, and the absolute cycle its response is due by.
    int          m_phase = 0;   // 0 none, 1 offered, 2 awaiting response, 3 delivering
    logic [15:0] m_addr = '0;
    logic [15:0] m_data = '0;
    logic        m_wr = 1'b0;
    logic [15:0] m_hold = '0;
    logic        m_eto = 1'b0;
    logic        m_eux = 1'b0;
    int          m_deadline = 0;

    // Observations for the directed checks.
    logic        seen_rinc = 1'b0;
    int          cnt_rinc = 0;
    int          cnt_valid = 0;
    int          acc_cyc = 0;
    int          eto_cyc = -1;
    logic [32:0] acc_q[$];
    logic [15:0] winc_q[$];

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic void refresh_head();
        send_fifo_empty = (fifo.size() == 0);
        if (fifo.size() != 0) begin
            send_attr_addr  = fifo[0].addr;
            send_attr_wdata = fifo[0].wdata;
            send_attr_wr    = fifo[0].wr;
        end else begin
            send_attr_addr  = '0;
            send_attr_wdata = '0;
            send_attr_wr    = 1'b0;
        end
    endfunction

    function automatic void push_req(input logic [15:0] a, input logic [15:0] d, input logic w);
        req_t r;
        r.addr = a; r.wdata = d; r.wr = w;
        fifo.push_back(r);
        refresh_head();
    endfunction

    function automatic void clear_obs();
        cnt_rinc = 0; cnt_valid = 0; eto_cyc = -1;
        acc_q.delete(); winc_q.delete();
    endfunction

    // One clock: compare on the falling edge against the reference, advance
    // the reference, then let the send FIFO react to a pop after the rising edge.
    task automatic tick();
        logic        e_rinc, e_winc;
        logic [15:0] e_rdata;
        logic        tmo;
        @(negedge link_clk);
        e_rinc  = !link_reset && m_phase == 0 && enable && !send_fifo_empty;
        e_winc  = !link_reset && ((m_phase == 2 && attr_rsp_valid && !recv_fifo_full) ||
                                  (m_phase == 3 && !recv_fifo_full));
        e_rdata = (m_phase == 2 && attr_rsp_valid) ? attr_rsp_data : m_hold;
        chk("rinc",    33'(send_fifo_rinc), 33'(e_rinc));
        chk("winc",    33'(recv_fifo_winc), 33'(e_winc));
        chk("rdata",   33'(recv_attr_rdata), 33'(e_rdata));
        chk("valid",   33'(attr_pkt_valid), 33'(m_phase == 1));
        chk("busy",    33'(attr_busy), 33'(m_phase != 0));
        chk("addr",    33'(attr_pkt_addr), 33'(m_addr));
        chk("data",    33'(attr_pkt_data), 33'(m_data));
        chk("wr",      33'(attr_pkt_wr), 33'(m_wr));
        chk("err_to",  33'(err_timeout), 33'(m_eto));
        chk("err_ux",  33'(err_unexp_rsp), 33'(m_eux));

        seen_rinc = send_fifo_rinc;
        if (send_fifo_rinc) cnt_rinc++;
        if (attr_pkt_valid) cnt_valid++;
        if (attr_pkt_valid && attr_pkt_ready) begin
            acc_q.push_back({attr_pkt_wr, attr_pkt_data, attr_pkt_addr});
            acc_cyc = cyc;
        end
        if (recv_fifo_winc) winc_q.push_back(recv_attr_rdata);
        if (err_timeout && eto_cyc < 0) eto_cyc = cyc;

        if (link_reset) begin
            m_phase = 0; m_addr = '0; m_data = '0; m_wr = 1'b0;
            m_hold = '0; m_eto = 1'b0; m_eux = 1'b0;
        end else begin
            tmo   = (m_phase == 2) && !attr_rsp_valid && (cyc == m_deadline);
            m_eux = (attr_rsp_valid && m_phase != 2) || (m_eux && !err_clr);
            m_eto = tmo || (m_eto && !err_clr);
            case (m_phase)
                0: if (e_rinc) begin
                    m_phase = 1;
                    m_addr  = send_attr_addr;
                    m_data  = send_attr_wr ? send_attr_wdata : 16'h0;
                    m_wr    = send_attr_wr;
                end
                1: if (attr_pkt_ready) begin
                    m_phase    = m_wr ? 0 : 2;
                    m_deadline = cyc + TO;
                end
                2: if (attr_rsp_valid) begin
                    m_hold  = attr_rsp_data;
                    m_phase = recv_fifo_full ? 3 : 0;
                end else if (tmo) begin
                    m_hold  = TIMEOUT_RDATA_DEFAULT;
                    m_phase = 3;
                end
                default: if (!recv_fifo_full) m_phase = 0;
            endcase
        end

        @(posedge link_clk);
        cyc++;
        #1;
        if (seen_rinc && fifo.size() != 0) begin
            void'(fifo.pop_front());
            refresh_head();
        end
    endtask

    task automatic wait_accept(input string name);
        for (int n = 0; n < 40 && acc_q.size() == 0; n++) tick();
        chk(name, 33'(acc_q.size()), 33'd1);
    endtask

    initial begin
        refresh_head();
        @(posedge link_clk);
        #1;
        for (int i = 0; i < 3; i++) tick();
        chk("reset_outs", 33'({send_fifo_rinc, attr_pkt_valid, attr_busy, recv_fifo_winc,
                               err_timeout, err_unexp_rsp, attr_pkt_addr}), 33'd0);
        link_reset = 1'b0;
        enable = 1'b1;
        attr_pkt_ready = 1'b1;
        tick();

        // Single write.
        clear_obs();
        push_req(16'h0010, 16'hBEEF, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        chk("wr_pops", 33'(cnt_rinc), 33'd1);
        chk("wr_valid_cycles", 33'(cnt_valid), 33'd1);
        chk("wr_no_winc", 33'(winc_q.size()), 33'd0);
        chk("wr_pkt", (acc_q.size() == 1) ? acc_q[0] : 33'h0, {1'b1, 16'hBEEF, 16'h0010});

        // Read answered five cycles after the accept.
        clear_obs();
        push_req(16'h0020, 16'h5555, 1'b0);
        wait_accept("rd_accept");
        for (int i = 0; i < 4; i++) tick();
        attr_rsp_valid = 1'b1; attr_rsp_data = 16'h1234;
        tick();
        attr_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("rd_pkt", (acc_q.size() == 1) ? acc_q[0] : 33'h1, {1'b0, 16'h0000, 16'h0020});
        chk("rd_winc_count", 33'(winc_q.size()), 33'd1);
        chk("rd_winc_data", (winc_q.size() != 0) ? 33'(winc_q[0]) : 33'h1_0000, 33'h1234);

        // Read with no response: error and fill value after TO waiting cycles.
        clear_obs();
        push_req(16'h0030, 16'h0, 1'b0);
        wait_accept("to_accept");
        for (int n = 0; n < 30 && eto_cyc < 0; n++) tick();
        tick();
        chk("to_latency", 33'(eto_cyc - acc_cyc), 33'(TO + 1));
        chk("to_winc_data", (winc_q.size() == 1) ? 33'(winc_q[0]) : 33'h1_0000, 33'hFFFF);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_cleared", 33'(err_timeout), 33'd0);

        // Response while the recv FIFO is full.
        clear_obs();
        recv_fifo_full = 1'b1;
        push_req(16'h0040, 16'h0, 1'b0);
        wait_accept("full_accept");
        tick(); tick();
        attr_rsp_valid = 1'b1; attr_rsp_data = 16'hA5A5;
        tick();
        attr_rsp_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("full_no_winc", 33'(winc_q.size()), 33'd0);
        chk("full_busy", 33'(attr_busy), 33'd1);
        recv_fifo_full = 1'b0;
        tick(); tick();
        chk("full_winc", (winc_q.size() == 1) ? 33'(winc_q[0]) : 33'h1_0000, 33'hA5A5);
        chk("full_idle", 33'(attr_busy), 33'd0);

        // Three queued writes, each held off for three cycles.
        clear_obs();
        attr_pkt_ready = 1'b0;
        push_req(16'h0100, 16'h1111, 1'b1);
        push_req(16'h0101, 16'h2222, 1'b1);
        push_req(16'h0102, 16'h3333, 1'b1);
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 10 && !attr_pkt_valid; n++) tick();
            for (int i = 0; i < 3; i++) tick();
            attr_pkt_ready = 1'b1;
            tick();
            attr_pkt_ready = 1'b0;
        end
        tick();
        chk("q_pops", 33'(cnt_rinc), 33'd3);
        chk("q_count", 33'(acc_q.size()), 33'd3);
        chk("q_first", (acc_q.size() == 3) ? acc_q[0] : 33'h0, {1'b1, 16'h1111, 16'h0100});
        chk("q_last",  (acc_q.size() == 3) ? acc_q[2] : 33'h0, {1'b1, 16'h3333, 16'h0102});

        // Reset while waiting for a read response.
        clear_obs();
        attr_pkt_ready = 1'b1;
        push_req(16'h0050, 16'h0, 1'b0);
        wait_accept("rst_accept");
        tick(); tick();
        link_reset = 1'b1;
        tick();
        link_reset = 1'b0;
        chk("rst_mid_outs", 33'({attr_pkt_valid, attr_busy, attr_pkt_addr, err_timeout}), 33'd0);
        attr_rsp_valid = 1'b1; attr_rsp_data = 16'h7777;
        tick();
        attr_rsp_valid = 1'b0;
        tick();
        chk("late_rsp_err", 33'(err_unexp_rsp), 33'd1);
        chk("late_rsp_no_winc", 33'(winc_q.size()), 33'd0);
        // Clear coinciding with a new error: the flag stays set.
        err_clr = 1'b1; attr_rsp_valid = 1'b1;
        tick();
        attr_rsp_valid = 1'b0;
        chk("clr_vs_set", 33'(err_unexp_rsp), 33'd1);
        tick();
        err_clr = 1'b0;
        chk("clr_done", 33'(err_unexp_rsp), 33'd0);

        // Randomized traffic against the reference.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) < 3 && fifo.size() < 4)
                push_req(16'($urandom), 16'($urandom), 1'($urandom));
            enable         = ($urandom_range(0, 15) != 0);
            attr_pkt_ready = ($urandom_range(0, 2) != 0);
            attr_rsp_valid = ($urandom_range(0, 5) == 0);
            attr_rsp_data  = 16'($urandom);
            recv_fifo_full = ($urandom_range(0, 3) == 0);
            err_clr        = ($urandom_range(0, 19) == 0);
            link_reset     = ($urandom_range(0, 299) == 0);
            tick();
        end
        link_reset = 1'b0; attr_rsp_valid = 1'b0; err_clr = 1'b0;
        for (int i = 0; i < 20; i++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
